// File: rtl/rvx10_pkg.sv
// Shared types and encodings for the RVX10 multicycle controller.
// Optional feature macro: RVX10_EXT_EN (custom-0 opcode decoded as an R-type op).
package rvx10_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } mc_state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_RVX = 7'b0001011;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  // True when DECODE has a path for this opcode; anything else is dropped.
  function automatic logic op_legal(input logic [6:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL: ok = 1'b1;
`ifdef RVX10_EXT_EN
      OP_RVX: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_nextstate.sv
// Combinational next-state function of the multicycle controller.
// Optional feature macro: RVX10_EXT_EN (custom-0 routed through EXECR).
import rvx10_pkg::*;

module mc_nextstate (
  input  mc_state_t  state,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output mc_state_t  state_next
);

  // Memory states hold until mem_ready; all others advance unconditionally.
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
`ifdef RVX10_EXT_EN
          OP_RVX:       state_next = S_EXECR;
`endif
          OP_I:         state_next = S_EXECI;
          OP_BR:        state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      default:    state_next = S_FETCH;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// RVX10 multicycle control FSM: state register plus Moore output decode.
// Optional feature macro: RVX10_EXT_EN (custom-0 opcode legal, executes as R-type).
//
// state      | meaning
// FETCH      | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE     | decode op, precompute branch target OldPC+imm
// MEMADR     | ALUOut <= rs1 + imm
// MEMREAD    | read data at ALUOut
// MEMWB      | rd <= Data
// MEMWRITE   | write rs2 to ALUOut address
// EXECR      | ALU on rs1, rs2 (also RVX10 ops when enabled)
// EXECI      | ALU on rs1, imm
// ALUWB      | rd <= ALUOut
// BEQ        | compare rs1/rs2, PC <= target when zero
// JAL        | ALUOut <= OldPC+4, PC <= jump target
import rvx10_pkg::*;

module mc_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       instr_done,
  output logic       illegal
);

  mc_state_t state_q;
  mc_state_t state_d;

  logic mem_req_raw, memwrite_raw, irwrite_raw, regwrite_raw;
  logic done_raw, illegal_raw, pcupdate, branch;

  mc_nextstate u_nextstate (
    .state      (state_q),
    .op         (op),
    .mem_ready  (mem_ready),
    .state_next (state_d)
  );

  // State register; reset parks the FSM in FETCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Moore decode of the state, with mem_ready/zero qualifying the strobes.
  always_comb begin
    mem_req_raw  = 1'b0;
    memwrite_raw = 1'b0;
    adrsrc       = 1'b0;
    irwrite_raw  = 1'b0;
    pcupdate     = 1'b0;
    branch       = 1'b0;
    regwrite_raw = 1'b0;
    resultsrc    = RES_ALUOUT;
    alusrca      = SRCA_PC;
    alusrcb      = SRCB_RS2;
    aluop        = ALUOP_ADD;
    done_raw     = 1'b0;
    illegal_raw  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_raw = 1'b1;
        resultsrc   = RES_ALURESULT;
        alusrcb     = SRCB_FOUR;
        irwrite_raw = mem_ready;
        pcupdate    = mem_ready;
      end
      S_DECODE: begin
        alusrca     = SRCA_OLDPC;
        alusrcb     = SRCB_IMM;
        illegal_raw = !op_legal(op);
      end
      S_MEMADR: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req_raw = 1'b1;
        adrsrc      = 1'b1;
      end
      S_MEMWB: begin
        resultsrc    = RES_DATA;
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_raw  = 1'b1;
        memwrite_raw = 1'b1;
        adrsrc       = 1'b1;
        done_raw     = mem_ready;
      end
      S_EXECR: begin
        alusrca = SRCA_RS1;
        aluop   = ALUOP_R;
      end
      S_EXECI: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_I;
      end
      S_ALUWB: begin
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      S_BEQ: begin
        alusrca  = SRCA_RS1;
        aluop    = ALUOP_BR;
        branch   = 1'b1;
        done_raw = 1'b1;
      end
      S_JAL: begin
        alusrca  = SRCA_OLDPC;
        alusrcb  = SRCB_FOUR;
        pcupdate = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated directly by reset so an aborted access drops at once.
  always_comb begin
    mem_req    = mem_req_raw & reset_n;
    memwrite   = memwrite_raw & reset_n;
    irwrite    = irwrite_raw & reset_n;
    pcwrite    = (pcupdate | (branch & zero)) & reset_n;
    regwrite   = regwrite_raw & reset_n;
    instr_done = done_raw & reset_n;
    illegal    = illegal_raw & reset_n;
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed, table-driven bench for mc_controller.
// Output word order: mem_req memwrite adrsrc irwrite pcwrite regwrite
//                    resultsrc alusrca alusrcb aluop instr_done illegal
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite;
  logic [1:0] resultsrc, alusrca, alusrcb, aluop;
  logic       instr_done, illegal;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .memwrite   (memwrite),
    .adrsrc     (adrsrc),
    .irwrite    (irwrite),
    .pcwrite    (pcwrite),
    .regwrite   (regwrite),
    .resultsrc  (resultsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .aluop      (aluop),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  localparam logic [6:0] O_R   = 7'b0110011;
  localparam logic [6:0] O_I   = 7'b0010011;
  localparam logic [6:0] O_LW  = 7'b0000011;
  localparam logic [6:0] O_SW  = 7'b0100011;
  localparam logic [6:0] O_BR  = 7'b1100011;
  localparam logic [6:0] O_JAL = 7'b1101111;
  localparam logic [6:0] O_RVX = 7'b0001011;
  localparam logic [6:0] O_BAD = 7'b1111111;

  //                           req mw  adr irw pcw rw   res    srca   srcb   aluop  done ill
  localparam logic [17:0] E_RST  = {6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [17:0] E_F1   = {6'b100110, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [17:0] E_F0   = {6'b100000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [17:0] E_DEC  = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
  localparam logic [17:0] E_DECI = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
  localparam logic [17:0] E_MA   = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
  localparam logic [17:0] E_MR   = {6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] E_MWB  = {6'b000001, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [17:0] E_MW0  = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [17:0] E_MW1  = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [17:0] E_EXR  = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
  localparam logic [17:0] E_EXI  = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00};
  localparam logic [17:0] E_AWB  = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [17:0] E_BQ1  = {6'b000010, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10};
  localparam logic [17:0] E_BQ0  = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10};
  localparam logic [17:0] E_JAL  = {6'b000010, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};

  typedef struct {
    logic [6:0]  op;
    logic        zero;
    logic        rdy;
    logic [17:0] exp;
    string       tag;
  } vec_t;

  vec_t vq[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic logic [17:0] outs();
    return {mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite,
            resultsrc, alusrca, alusrcb, aluop, instr_done, illegal};
  endfunction

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  task automatic add(input logic [6:0] o, input logic z, input logic r,
                     input logic [17:0] e, input string t);
    vec_t v;
    v.op = o; v.zero = z; v.rdy = r; v.exp = e; v.tag = t;
    vq.push_back(v);
  endtask

  initial begin
    // R-type, zero-wait: result write at cycle 4; zero ignored outside BEQ
    add(O_R, 0, 1, E_F1,  "r.fetch");
    add(O_R, 1, 1, E_DEC, "r.decode");
    add(O_R, 1, 1, E_EXR, "r.execr");
    add(O_R, 1, 0, E_AWB, "r.aluwb");
    // I-type
    add(O_I, 0, 1, E_F1,  "i.fetch");
    add(O_I, 0, 0, E_DEC, "i.decode");
    add(O_I, 0, 1, E_EXI, "i.execi");
    add(O_I, 0, 1, E_AWB, "i.aluwb");
    // load with 3 stall cycles in MEMREAD: 8 cycles total
    add(O_LW, 0, 1, E_F1,  "lw.fetch");
    add(O_LW, 0, 1, E_DEC, "lw.decode");
    add(O_LW, 0, 1, E_MA,  "lw.memadr");
    add(O_LW, 0, 0, E_MR,  "lw.memread0");
    add(O_LW, 0, 0, E_MR,  "lw.memread1");
    add(O_LW, 0, 0, E_MR,  "lw.memread2");
    add(O_LW, 0, 1, E_MR,  "lw.memread3");
    add(O_LW, 0, 0, E_MWB, "lw.memwb");
    // fetch stall, then store with one stall in MEMWRITE
    add(O_SW, 0, 0, E_F0,  "sw.fetch_stall");
    add(O_SW, 0, 1, E_F1,  "sw.fetch");
    add(O_SW, 0, 0, E_DEC, "sw.decode");
    add(O_SW, 0, 0, E_MA,  "sw.memadr");
    add(O_SW, 0, 0, E_MW0, "sw.memwrite_stall");
    add(O_SW, 0, 1, E_MW1, "sw.memwrite_done");
    // branch taken / not taken
    add(O_BR, 0, 1, E_F1,  "beq1.fetch");
    add(O_BR, 0, 0, E_DEC, "beq1.decode");
    add(O_BR, 1, 0, E_BQ1, "beq1.taken");
    add(O_BR, 1, 1, E_F1,  "beq0.fetch");
    add(O_BR, 1, 0, E_DEC, "beq0.decode");
    add(O_BR, 0, 0, E_BQ0, "beq0.not_taken");
    // JAL
    add(O_JAL, 0, 1, E_F1,  "jal.fetch");
    add(O_JAL, 0, 0, E_DEC, "jal.decode");
    add(O_JAL, 0, 0, E_JAL, "jal.jal");
    add(O_JAL, 0, 0, E_AWB, "jal.aluwb");
    // undecodable opcode: illegal at cycle 2, FETCH at cycle 3
    add(O_BAD, 0, 1, E_F1,   "bad.fetch");
    add(O_BAD, 0, 1, E_DECI, "bad.decode");
    add(O_BAD, 0, 0, E_F0,   "bad.refetch");
    // custom-0
    add(O_RVX, 0, 1, E_F1,  "rvx.fetch");
`ifdef RVX10_EXT_EN
    add(O_RVX, 0, 0, E_DEC, "rvx.decode");
    add(O_RVX, 0, 0, E_EXR, "rvx.execr");
    add(O_RVX, 0, 0, E_AWB, "rvx.aluwb");
`else
    add(O_RVX, 0, 0, E_DECI, "rvx.decode_illegal");
`endif
    add(O_R, 0, 0, E_F0, "rvx.refetch");

    // reset held: strobes forced low even with mem_ready/zero high
    reset_n = 1'b0; op = O_R; zero = 1'b1; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2 check("reset_held", outs(), E_RST);
    zero = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vq[i]) begin
      op = vq[i].op; zero = vq[i].zero; mem_ready = vq[i].rdy;
      #2 check(vq[i].tag, outs(), vq[i].exp);
      @(negedge clk);
    end

    // finish the pending fetch, then abort a store mid-MEMWRITE
    op = O_SW; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 check("abort.memwrite_before", outs(), E_MW0);
    reset_n = 1'b0;
    #1 check("abort.strobes_low", outs(), E_RST);
    @(negedge clk);
    mem_ready = 1'b1;
    #2 check("abort.held", outs(), E_RST);
    @(negedge clk);
    reset_n = 1'b1;
    mem_ready = 1'b0;
    #2 check("abort.resume_fetch", outs(), E_F0);
    mem_ready = 1'b1;
    #1 check("abort.fetch_ready", outs(), E_F1);
    @(negedge clk);
    #2 check("abort.decode", outs(), E_DEC);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control FSM for the RVX10 core. It sequences a shared datapath (one memory port, one ALU, and PC/IR/ALUOut/Data registers) through the fetch, decode, execute, memory and writeback steps of each instruction. It sits beside the ALU decoder: this block emits `aluop` and the datapath steering selects, and it stalls on a single request/ready memory handshake.

## Interface
Parameters: none.
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `op`  in  7  opcode of the instruction register
- `zero`  in  1  ALU zero flag (current cycle)
- `mem_ready`  in  1  memory completes the access this cycle
- `mem_req`  out  1  memory access request; held until `mem_ready`
- `memwrite`  out  1  store strobe; valid only with `mem_req`
- `adrsrc`  out  1  0 = PC, 1 = ALUOut as memory address
- `irwrite`  out  1  load IR and OldPC
- `pcwrite`  out  1  PC load enable, equal to `pcupdate | (branch & zero)`
- `regwrite`  out  1  register file write
- `resultsrc`  out  2  00 ALUOut, 01 Data, 10 ALUResult
- `alusrca`  out  2  00 PC, 01 OldPC, 10 rs1
- `alusrcb`  out  2  00 rs2, 01 imm, 10 constant 4
- `aluop`  out  2  00 add, 01 branch compare, 10 R-type, 11 I-type
- `instr_done`  out  1  one-cycle pulse on the final cycle of each instruction
- `illegal`  out  1  one-cycle pulse when an undecodable opcode is dropped

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- Outputs are Moore outputs of the state. The only exceptions are the `mem_ready`-qualified strobes and `pcwrite` via `zero`. Unlisted outputs are 0.
- FETCH:
  - Drives `mem_req=1`, `adrsrc=0`, `alusrca=00`, `alusrcb=10`, `aluop=00`, `resultsrc=10`.
  - `irwrite` and `pcupdate` are asserted only when `mem_ready=1`, which also moves the FSM to DECODE. Otherwise the FSM stays in FETCH.
- DECODE:
  - Drives `alusrca=01`, `alusrcb=01`, `aluop=00` to compute the branch target.
  - Next state by `op`: 0000011/0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BEQ; 1101111 → JAL.
  - Any other opcode → FETCH with `illegal=1`.
- MEMADR: drives `alusrca=10`, `alusrcb=01`, `aluop=00`. Next is MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: drives `mem_req=1`, `adrsrc=1`, `resultsrc=00`. Stays until `mem_ready`, then goes to MEMWB.
- MEMWB: drives `resultsrc=01`, `regwrite=1`, `instr_done=1`. Next is FETCH.
- MEMWRITE: drives `mem_req=1`, `memwrite=1`, `adrsrc=1`, `resultsrc=00`. On `mem_ready` it pulses `instr_done` and goes to FETCH.
- EXECR: drives `alusrca=10`, `alusrcb=00`, `aluop=10`. Next is ALUWB.
- EXECI: drives `alusrca=10`, `alusrcb=01`, `aluop=11`. Next is ALUWB.
- ALUWB: drives `resultsrc=00`, `regwrite=1`, `instr_done=1`. Next is FETCH.
- BEQ:
  - Drives `alusrca=10`, `alusrcb=00`, `aluop=01`, `resultsrc=00`, `branch=1`, `instr_done=1`.
  - `pcwrite` equals `zero`. Next is FETCH.
- JAL: drives `alusrca=01`, `alusrcb=10`, `aluop=00`, `resultsrc=00`, `pcupdate=1`. Next is ALUWB, which writes PC+4 to rd.

## Timing
- Reset (`reset_n` low, asynchronous):
  - State becomes FETCH.
  - `mem_req`, `memwrite`, `irwrite`, `pcwrite`, `regwrite`, `instr_done` and `illegal` are forced to 0 while reset is held.
  - Fetch begins on the first edge after deassertion.
- Reset asserted mid-access aborts the access; no write strobe may glitch high.
- Zero-wait memory gives these latencies: R/I-type 4 cycles, load 5, store 4, branch 3, JAL 4. Each stall cycle adds 1.
- `mem_req` and the address selects stay stable from request until the `mem_ready` cycle. `mem_ready` outside a request is ignored.
- `pcwrite` in BEQ is combinational on `zero` within the same cycle.

## Configuration
- `RVX10_EXT_EN`:
  - Defined: opcode 0001011 (custom-0, the RVX10 ops) decodes in DECODE → EXECR → ALUWB, with `aluop=10`. The ALU decoder separates these ops by `funct7`/`funct3`.
  - Undefined: 0001011 is illegal (`illegal` pulse, return to FETCH).

## Structure
- Shared package `rvx10_pkg` holds:
  - the state enum `mc_state_t`;
  - opcode localparams (`OP_R`, `OP_I`, `OP_LW`, `OP_SW`, `OP_BR`, `OP_JAL`, `OP_RVX`);
  - the `resultsrc`, `alusrca`, `alusrcb` and `aluop` encoding constants.
- One sub-module, `mc_nextstate`: the combinational next-state function of (state, op, mem_ready). The top keeps the state register and the output decode.

## Test plan
- Reset released, then `op=0110011`, `mem_ready=1`: states FETCH→DECODE→EXECR→ALUWB; `regwrite=1` and `instr_done=1` exactly at cycle 4; `aluop=10` in EXECR.
- Load with `mem_ready` low for 3 cycles in MEMREAD: total 8 cycles; `mem_req` high and `adrsrc=1` for all 4 MEMREAD cycles; `resultsrc=01` in MEMWB.
- Store (`op=0100011`): `memwrite=1` only in MEMWRITE; `instr_done` coincides with `mem_ready`; `regwrite` never asserts.
- BEQ with `zero=1` → `pcwrite=1` at cycle 3; repeat with `zero=0` → `pcwrite=0`, `instr_done=1`.
- `op=0001011`: with `RVX10_EXT_EN` → ALUWB at cycle 4; without it → `illegal` pulse at cycle 2 and FETCH at cycle 3. `op=1111111` → `illegal` in both builds.
- `reset_n` dropped mid-MEMWRITE: `memwrite`/`mem_req` fall asynchronously; FSM resumes at FETCH.
